fabric_arb2_sched: RTL

FABRIC_ARB2_SCHED -- requirements
Module: fabric_arb2_sched

---
 rtl/fabric_arb2_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fabric_arb2_sched.sv
// Two-master to one-slave request scheduler with round-robin grant.
// Keeps one transaction in flight and has an optional response timeout.
module fabric_arb2_sched #(
  parameter int          ADDR_W            = 32,
  parameter int          DATA_W            = 32,
  parameter int          ID_W              = 4,
  parameter int          ATTR_W            = 8,
  parameter int          TIMEOUT_CYC       = 256,
  parameter logic [7:0]  RESP_TIMEOUT_CODE = 8'hFE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            m_req_valid,
  output logic [1:0]            m_req_ready,
  input  logic [2*8-1:0]        m_req_op,
  input  logic [2*ADDR_W-1:0]   m_req_addr,
  input  logic [2*DATA_W-1:0]   m_req_wdata,
  input  logic [2*DATA_W/8-1:0] m_req_wstrb,
  input  logic [2*3-1:0]        m_req_size,
  input  logic [2*ATTR_W-1:0]   m_req_attr,
  input  logic [2*ID_W-1:0]     m_req_id,
  output logic [1:0]            m_rsp_valid,
  input  logic [1:0]            m_rsp_ready,
  output logic [DATA_W-1:0]     m_rsp_rdata,
  output logic [7:0]            m_rsp_code,
  output logic [ID_W-1:0]       m_rsp_id,
  output logic                  s_req_valid,
  input  logic                  s_req_ready,
  output logic [7:0]            s_req_op,
  output logic [ADDR_W-1:0]     s_req_addr,
  output logic [DATA_W-1:0]     s_req_wdata,
  output logic [DATA_W/8-1:0]   s_req_wstrb,
  output logic [2:0]            s_req_size,
  output logic [ATTR_W-1:0]     s_req_attr,
  output logic [ID_W-1:0]       s_req_id,
  input  logic                  s_rsp_valid,
  output logic                  s_rsp_ready,
  input  logic [DATA_W-1:0]     s_rsp_rdata,
  input  logic [7:0]            s_rsp_code,
  input  logic [ID_W-1:0]       s_rsp_id,
  output logic                  busy,
  output logic                  owner,
  output logic                  stray_rsp
);

  localparam int SW = DATA_W / 8;
  localparam int CW = (TIMEOUT_CYC > 0) ?
                      $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef struct packed {
    logic [7:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SW-1:0]     wstrb;
    logic [2:0]        size;
    logic [ATTR_W-1:0] attr;
    logic [ID_W-1:0]   id;
  } req_t;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t            state;
  req_t              req;
  req_t              sel;
  logic              win;
  logic              last_grant;
  logic              accept;
  logic              id_hit;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rsp_rdata;
  logic [7:0]        rsp_code;

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (m_req_valid == 2'b11): win = ~last_grant;
      (m_req_valid == 2'b10): win = 1'b1;
      default:                win = 1'b0;
    endcase
  end

  always_comb begin
    sel = '0;
    if (win)
      sel = {m_req_op[15:8],
             m_req_addr[2*ADDR_W-1:ADDR_W],
             m_req_wdata[2*DATA_W-1:DATA_W],
             m_req_wstrb[2*SW-1:SW],
             m_req_size[5:3],
             m_req_attr[2*ATTR_W-1:ATTR_W],
             m_req_id[2*ID_W-1:ID_W]};
    else
      sel = {m_req_op[7:0],
             m_req_addr[ADDR_W-1:0],
             m_req_wdata[DATA_W-1:0],
             m_req_wstrb[SW-1:0],
             m_req_size[2:0],
             m_req_attr[ATTR_W-1:0],
             m_req_id[ID_W-1:0]};
  end

  assign m_req_ready = (rst_n && state == IDLE) ?
                       (m_req_valid & (win ? 2'b10 : 2'b01)) :
                       2'b00;
  assign accept      = |m_req_ready;
  assign s_rsp_ready = rst_n && (state != RESP);
  assign id_hit      = (s_rsp_id == req.id);

  assign s_req_valid = (state == ISSUE);
  assign s_req_op    = req.op;
  assign s_req_addr  = req.addr;
  assign s_req_wdata = req.wdata;
  assign s_req_wstrb = req.wstrb;
  assign s_req_size  = req.size;
  assign s_req_attr  = req.attr;
  assign s_req_id    = req.id;

  assign m_rsp_valid = (state == RESP) ?
                       (owner ? 2'b10 : 2'b01) : 2'b00;
  assign m_rsp_rdata = rsp_rdata;
  assign m_rsp_code  = rsp_code;
  assign m_rsp_id    = req.id;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      rsp_rdata  <= '0;
      rsp_code   <= '0;
      stray_rsp  <= 1'b0;
    end else begin
      if (s_rsp_valid && s_rsp_ready &&
          !(state == WAIT && id_hit))
        stray_rsp <= 1'b1;
      unique case (state)
        IDLE: if (accept) begin
          req        <= sel;
          owner      <= win;
          last_grant <= win;
          state      <= ISSUE;
        end
        ISSUE: if (s_req_ready) begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // a matching response beats a same-cycle timeout
          if (s_rsp_valid && id_hit) begin
            rsp_rdata <= s_rsp_rdata;
            rsp_code  <= s_rsp_code;
            state     <= RESP;
          end else begin
            if (cnt != '1)
              cnt <= cnt + CW'(1);
            if (TO_EN && cnt == TO_LAST) begin
              rsp_rdata <= '0;
              rsp_code  <= RESP_TIMEOUT_CODE;
              state     <= RESP;
            end
          end
        end
        RESP: if (m_rsp_ready[owner])
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
